// File: rtl/uart_rx_fifo_if.sv
// Host/receiver-facing signal bundle for uart_rx_fifo.
// The slave modport is the FIFO side and the master modport is the receiver/host side.
interface uart_rx_fifo_if #(
    parameter int AW = 4
);
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        rx_busy;
    logic        fifo_en;
    logic        rx_en;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready;
    logic [AW:0] count;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        ovf_clr;
    logic        timeout;

    modport slave (
        input  rx_data, rx_done, rx_busy, fifo_en, dout_ready, ovf_clr,
        output rx_en, dout, dout_valid, count, full, empty, overflow, timeout
    );

    modport master (
        output rx_data, rx_done, rx_busy, fifo_en, dout_ready, ovf_clr,
        input  rx_en, dout, dout_valid, count, full, empty, overflow, timeout
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: edge-captures rx_done into a FWFT FIFO.
// Optional idle-timeout flag is built when RX_TIMEOUT_EN is defined.
module uart_rx_fifo #(
    parameter int DEPTH          = 16,
    parameter int AW             = 4,
    parameter int TIMEOUT_CYCLES = 41670
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_fifo_if.slave  bus
);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          done_q;
    logic          overflow_q;

    logic push_req;
    logic pop;
    logic full;
    logic empty;
    logic wr_en;
    logic drop;

    assign full     = (count == CNT_MAX);
    assign empty    = (count == '0);
    assign push_req = bus.rx_done & ~done_q;
    assign pop      = ~empty & bus.dout_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign wr_en    = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= bus.rx_done;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_ptr] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !wr_en) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // Set has priority over a simultaneous clear so a drop is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (bus.ovf_clr) begin
            overflow_q <= 1'b0;
        end
    end

`ifdef RX_TIMEOUT_EN
    localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] idle_cnt;
    logic        timeout_q;
    logic        idle_clr;

    assign idle_clr = push_req | pop | empty | bus.rx_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (idle_clr) begin
            idle_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (idle_cnt == IDLE_LAST) begin
            timeout_q <= 1'b1;
        end else begin
            idle_cnt <= idle_cnt + 16'd1;
        end
    end

    assign bus.timeout = timeout_q;
`else
    logic [32:0] unused_cfg;
    assign unused_cfg  = {bus.rx_busy, 32'(TIMEOUT_CYCLES)};
    assign bus.timeout = 1'b0;
`endif

    assign bus.rx_en      = bus.fifo_en & ~full;
    assign bus.dout       = mem[rd_ptr];
    assign bus.dout_valid = ~empty;
    assign bus.count      = count;
    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized and directed bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int TO    = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_fifo_if #(.AW(AW)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] q [$];
    bit         m_done_q = 1'b0;
    bit         m_ovf    = 1'b0;
    int         m_idle   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic cyc(input bit r, input bit done, input logic [7:0] data,
                       input bit ready, input bit clr, input bit busy, input bit en);
        int sz;
        bit pe, pp, idle_clr, dropped;
        @(negedge clk);
        rst = r;
        bus.rx_done = done; bus.rx_data = data; bus.dout_ready = ready;
        bus.ovf_clr = clr;  bus.rx_busy = busy; bus.fifo_en = en;
        #1;
        sz = q.size();
        chk("count", 32'(bus.count), 32'(sz));
        chk("empty", 32'(bus.empty), 32'(sz == 0));
        chk("full", 32'(bus.full), 32'(sz == DEPTH));
        chk("dout_valid", 32'(bus.dout_valid), 32'(sz != 0));
        if (sz != 0) chk("dout", 32'(bus.dout), 32'(q[0]));
        chk("rx_en", 32'(bus.rx_en), 32'(en && sz != DEPTH));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
`ifdef RX_TIMEOUT_EN
        chk("timeout", 32'(bus.timeout), 32'(m_idle >= TO));
`else
        chk("timeout", 32'(bus.timeout), 32'(0));
`endif
        if (r) begin
            q.delete();
            m_done_q = 1'b0; m_ovf = 1'b0; m_idle = 0;
            return;
        end
        pe = done && !m_done_q;
        pp = ready && sz != 0;
        idle_clr = pe || pp || sz == 0 || busy;
        dropped = 1'b0;
        if (pp) void'(q.pop_front());
        if (pe) begin
            if (sz < DEPTH || pp) q.push_back(data);
            else dropped = 1'b1;
        end
        if (dropped) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_done_q = done;
        m_idle = idle_clr ? 0 : m_idle + 1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        cyc(0, 1, d, 0, 0, 0, 1);
        cyc(0, 0, d, 0, 0, 0, 1);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, 1, 0, 0, 1);
    endtask

    initial begin
        logic [7:0] rd;
        bit         dn;
        bus.rx_done = 1'b0; bus.rx_data = '0; bus.dout_ready = 1'b0;
        bus.ovf_clr = 1'b0; bus.rx_busy = 1'b0; bus.fifo_en = 1'b1;

        cyc(1, 0, 8'h00, 0, 0, 0, 1);
        cyc(1, 0, 8'h00, 0, 0, 0, 1);

        // Long held done level must produce a single byte.
        for (int i = 0; i < 20834; i++) cyc(0, 1, 8'hA5, 0, 0, 0, 1);
        cyc(0, 0, 8'hA5, 0, 0, 0, 1);
        cyc(0, 0, 8'h00, 1, 0, 0, 1);
        cyc(0, 0, 8'h00, 0, 0, 0, 1);

        // Fill/drain three times to wrap the pointers.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) push_byte(8'(i));
            cyc(0, 0, 8'h00, 0, 0, 0, 1);
            drain(17);
        end

        // Overflow, set-beats-clear, then clear alone.
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        push_byte(8'h55);
        cyc(0, 1, 8'h66, 0, 1, 0, 1);
        cyc(0, 0, 8'h66, 0, 0, 0, 1);
        cyc(0, 0, 8'h00, 0, 1, 0, 1);
        cyc(0, 0, 8'h00, 0, 0, 0, 1);

        // Push into a full FIFO while the head is popped.
        cyc(0, 1, 8'h77, 1, 0, 0, 1);
        cyc(0, 0, 8'h77, 0, 0, 0, 1);
        drain(17);

        // Reset with contents and a high done level; release counts as an edge.
        for (int i = 0; i < 5; i++) push_byte(8'h30 + 8'(i));
        cyc(1, 1, 8'hC3, 0, 0, 0, 1);
        cyc(1, 1, 8'hC3, 0, 0, 0, 1);
        cyc(0, 1, 8'hC3, 0, 0, 0, 1);
        cyc(0, 1, 8'hC3, 0, 0, 0, 1);
        cyc(0, 0, 8'hC3, 0, 0, 0, 1);
        drain(2);

        // Idle timeout on a single stored byte, then pop.
        push_byte(8'h5A);
        for (int i = 0; i < TO + 8; i++) cyc(0, 0, 8'h00, 0, 0, 0, 1);
        cyc(0, 0, 8'h00, 1, 0, 0, 1);
        cyc(0, 0, 8'h00, 0, 0, 0, 1);
        cyc(0, 0, 8'h00, 0, 0, 0, 1);

        // Randomized traffic; data only changes while done is low.
        rd = 8'h00;
        dn = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            bit r;
            r = ($urandom_range(0, 199) == 0);
            if (!dn) rd = 8'($urandom);
            dn = ($urandom_range(0, 99) < 45);
            cyc(r, dn, rd, ($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 5),
                ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 90));
        end
        cyc(0, 0, 8'h00, 0, 0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
